// File: rtl/imem_arbiter.sv
// rtl/imem_arbiter.sv - shared instruction RAM arbiter: boot loader writes, then fetch/loader sharing.
// Define IMEM_RR_EN for round-robin arbitration in RUN; default is fixed priority (loader wins).
module imem_arbiter #(
  parameter int          ADDR_W   = 10,
  parameter logic [31:0] NOP_WORD = 32'h00000013
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              f_req,
  input  logic [31:0]       f_addr,
  output logic              f_gnt,
  output logic              f_rvalid,
  output logic [31:0]       f_rdata,
  input  logic              l_req,
  input  logic [31:0]       l_addr,
  input  logic [31:0]       l_wdata,
  output logic              l_gnt,
  input  logic              l_done,
  output logic              boot_done,
  output logic              m_en,
  output logic              m_we,
  output logic [ADDR_W-1:0] m_addr,
  output logic [31:0]       m_wdata,
  input  logic [31:0]       m_rdata
);

  typedef enum logic {S_BOOT, S_RUN} state_t;

  state_t r_state;
  logic   r_boot_done;
  logic   r_rvalid;
  logic   r_oor;
`ifdef IMEM_RR_EN
  logic   r_prio_l;
`endif

  logic w_lg;
  logic w_fg;
  logic w_l_oor;
  logic w_f_oor;
  logic w_unused;

  assign w_l_oor  = |l_addr[31:ADDR_W+2];
  assign w_f_oor  = |f_addr[31:ADDR_W+2];
  assign w_unused = ^{f_addr[1:0], l_addr[1:0]};

  always_comb begin
    w_lg = 1'b0;
    w_fg = 1'b0;
    if (rst_n) begin
      if (r_state == S_BOOT) begin
        w_lg = l_req;
      end else if (l_req && f_req) begin
`ifdef IMEM_RR_EN
        w_lg = r_prio_l;
        w_fg = !r_prio_l;
`else
        w_lg = 1'b1;
`endif
      end else begin
        w_lg = l_req;
        w_fg = f_req;
      end
    end
  end

  assign l_gnt   = w_lg;
  assign f_gnt   = w_fg;
  // Out-of-range accesses are still granted, but never reach the RAM.
  assign m_en    = (w_lg && !w_l_oor) || (w_fg && !w_f_oor);
  assign m_we    = w_lg && !w_l_oor;
  assign m_addr  = w_lg ? l_addr[ADDR_W+1:2] : (w_fg ? f_addr[ADDR_W+1:2] : '0);
  assign m_wdata = w_lg ? l_wdata : 32'h0;

  assign boot_done = r_boot_done;
  assign f_rvalid  = r_rvalid;
  assign f_rdata   = (r_rvalid && !r_oor) ? m_rdata : NOP_WORD;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_BOOT;
      r_boot_done <= 1'b0;
      r_rvalid    <= 1'b0;
      r_oor       <= 1'b0;
`ifdef IMEM_RR_EN
      r_prio_l    <= 1'b1;
`endif
    end else begin
      if (r_state == S_BOOT && l_done) begin
        r_state     <= S_RUN;
        r_boot_done <= 1'b1;
      end
      r_rvalid <= w_fg;
      r_oor    <= w_fg && w_f_oor;
`ifdef IMEM_RR_EN
      // Priority passes to whichever side was not just served.
      if (r_state == S_RUN) begin
        if (w_lg)      r_prio_l <= 1'b0;
        else if (w_fg) r_prio_l <= 1'b1;
      end
`endif
    end
  end

endmodule

// File: tb/tb_imem_arbiter.sv
// tb/tb_imem_arbiter.sv - scoreboard bench for imem_arbiter with a RAM model and reference model.
module tb_imem_arbiter;

  localparam logic [31:0] NOP = 32'h00000013;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        f_req = 1'b0;
  logic [31:0] f_addr = '0;
  logic        l_req = 1'b0;
  logic [31:0] l_addr = '0;
  logic [31:0] l_wdata = '0;
  logic        l_done = 1'b0;
  logic        f_gnt, f_rvalid, l_gnt, boot_done, m_en, m_we;
  logic [31:0] f_rdata, m_wdata;
  logic [9:0]  m_addr;
  logic [31:0] m_rdata;

  imem_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .f_req(f_req), .f_addr(f_addr), .f_gnt(f_gnt), .f_rvalid(f_rvalid), .f_rdata(f_rdata),
    .l_req(l_req), .l_addr(l_addr), .l_wdata(l_wdata), .l_gnt(l_gnt),
    .l_done(l_done), .boot_done(boot_done),
    .m_en(m_en), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata), .m_rdata(m_rdata)
  );

  always #5 clk = ~clk;

  logic [31:0] ram [1024];
  always @(posedge clk) begin
    if (m_en && m_we)  ram[m_addr] <= m_wdata;
    if (m_en && !m_we) m_rdata <= ram[m_addr];
  end

  typedef struct {int cyc; logic [31:0] d;} rsp_t;
  rsp_t q[$];

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  bit started = 0;

  bit          mdl_boot = 1;
  bit          mdl_prio_l = 1;
  logic [31:0] ref_mem [1024];

  bit          e_fg, e_lg, e_men, e_mwe, e_boot_done, e_rst;
  logic [9:0]  e_maddr;
  logic [31:0] e_mwdata;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s (cycle %0d): got %h expected %h", nm, cyc, act, exp);
    end
  endtask

  always @(posedge clk) cyc = cyc + 1;

  task automatic step(input bit rst, input bit fr, input logic [31:0] fa,
                      input bit lr, input logic [31:0] la, input logic [31:0] lw, input bit ld);
    bit lg, fg, l_in, f_in;
    rsp_t r;
    @(posedge clk);
    #1;
    rst_n = !rst; f_req = fr; f_addr = fa; l_req = lr; l_addr = la; l_wdata = lw; l_done = ld;
    e_rst = rst;
    if (rst) begin
      mdl_boot = 1; mdl_prio_l = 1; q.delete();
      e_fg = 0; e_lg = 0; e_men = 0; e_mwe = 0; e_boot_done = 0; e_maddr = '0; e_mwdata = '0;
    end else begin
      e_boot_done = !mdl_boot;
      lg = 0; fg = 0;
      if (mdl_boot) lg = lr;
      else if (fr && lr) begin
`ifdef IMEM_RR_EN
        if (mdl_prio_l) lg = 1; else fg = 1;
`else
        lg = 1;
`endif
      end else begin
        lg = lr; fg = fr;
      end
      l_in = la < 32'h1000;
      f_in = fa < 32'h1000;
      e_lg = lg; e_fg = fg;
      e_men = (lg && l_in) || (fg && f_in);
      e_mwe = lg && l_in;
      e_maddr = lg ? la[11:2] : fa[11:2];
      e_mwdata = lw;
      if (lg && l_in) ref_mem[la[11:2]] = lw;
      if (fg) begin
        r.cyc = cyc;
        r.d = f_in ? ref_mem[fa[11:2]] : NOP;
        q.push_back(r);
      end
      if (!mdl_boot) begin
        if (lg) mdl_prio_l = 0;
        else if (fg) mdl_prio_l = 1;
      end
      if (mdl_boot && ld) mdl_boot = 0;
    end
    started = 1;
  endtask

  always @(negedge clk) begin
    if (started) begin
      chk("f_gnt", {31'b0, f_gnt}, {31'b0, e_fg});
      chk("l_gnt", {31'b0, l_gnt}, {31'b0, e_lg});
      chk("m_en", {31'b0, m_en}, {31'b0, e_men});
      chk("m_we", {31'b0, m_we}, {31'b0, e_mwe});
      chk("boot_done", {31'b0, boot_done}, {31'b0, e_boot_done});
      if (e_men) chk("m_addr", {22'b0, m_addr}, {22'b0, e_maddr});
      if (e_mwe) chk("m_wdata", m_wdata, e_mwdata);
      if (e_rst) begin
        chk("rst_m_addr", {22'b0, m_addr}, 32'h0);
        chk("rst_m_wdata", m_wdata, 32'h0);
      end
    end
  end

  always @(negedge clk) begin
    bit exp_v;
    if (started) begin
      exp_v = (q.size() > 0) && (q[0].cyc == cyc - 1);
      chk("f_rvalid", {31'b0, f_rvalid}, {31'b0, exp_v});
      if (exp_v) begin
        chk("f_rdata", f_rdata, q[0].d);
        void'(q.pop_front());
      end else begin
        chk("f_rdata_idle", f_rdata, NOP);
      end
    end
  end

  function automatic logic [31:0] rand_addr();
    logic [31:0] a;
    if ($urandom_range(0, 9) == 0) a = $urandom() | 32'h0000_1000;
    else a = {26'b0, 4'($urandom_range(0, 15)), 2'($urandom())};
    return a;
  endfunction

  initial begin
    logic [31:0] v;
    for (int i = 0; i < 1024; i++) begin
      v = $urandom();
      ram[i] = v;
      ref_mem[i] = v;
    end
    m_rdata = '0;

    step(1, 0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 1, 32'h0, 32'h00100093, 0);
    step(0, 0, 0, 0, 0, 0, 1);
    step(0, 1, 32'h0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0);

    step(1, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 5; i++) step(0, 1, 32'h4, 0, 0, 0, 0);
    step(0, 1, 32'h4, 0, 0, 0, 1);
    step(0, 1, 32'h4, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0);

    for (int i = 0; i < 4; i++) step(0, 1, 32'h8, 1, 32'h10 + 32'(i * 4), 32'hA000_0000 + 32'(i), 0);
    step(0, 0, 0, 0, 0, 0, 0);

    step(0, 1, 32'h0000_1000, 0, 0, 0, 0);
    step(0, 0, 0, 1, 32'h0000_1000, 32'hDEAD_BEEF, 0);
    step(0, 1, 32'h6, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0);

    step(0, 1, 32'h10, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0);
    step(0, 1, 32'h10, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0);

    for (int i = 0; i < 1500; i++) begin
      step($urandom_range(0, 199) == 0, 1'($urandom()), rand_addr(),
           $urandom_range(0, 2) == 0, rand_addr(), $urandom(), $urandom_range(0, 11) == 0);
    end
    step(0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0);
    @(posedge clk);
    #1;
    chk("queue_drained", q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/imem_arbiter.md
IMEM_ARBITER -- requirements
Module: imem_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 10, word-address width of the shared instruction RAM (1024 words).
REQ-002 SHALL have parameter NOP_WORD, default 32'h00000013, word returned for out-of-range fetches.
REQ-003 SHALL have port clk, input, 1, the only clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n, input, 1, reset, asynchronous and active-low.
REQ-005 SHALL have port f_req, input, 1, fetch read request.
REQ-006 SHALL have port f_addr, input, 32, fetch byte address.
REQ-007 SHALL have port f_gnt, output, 1, fetch accepted this cycle.
REQ-008 SHALL have port f_rvalid, output, 1, f_rdata valid, one cycle after f_gnt.
REQ-009 SHALL have port f_rdata, output, 32, fetched word.
REQ-010 SHALL have port l_req, input, 1, loader write request.
REQ-011 SHALL have port l_addr, input, 32, loader byte address.
REQ-012 SHALL have port l_wdata, input, 32, loader write data.
REQ-013 SHALL have port l_gnt, output, 1, loader write accepted this cycle.
REQ-014 SHALL have port l_done, input, 1, single-cycle pulse ending the boot load.
REQ-015 SHALL have port boot_done, output, 1, high once in RUN.
REQ-016 SHALL have port m_en, output, 1, RAM port enable.
REQ-017 SHALL have port m_we, output, 1, RAM write enable.
REQ-018 SHALL have port m_addr, output, ADDR_W, RAM word address.
REQ-019 SHALL have port m_wdata, output, 32, RAM write data.
REQ-020 SHALL have port m_rdata, input, 32, RAM read data, valid the cycle after m_en high with m_we low.

Function
REQ-021 SHALL implement an FSM with states BOOT and RUN: BOOT->RUN on l_done; RUN is terminal until reset.
REQ-022 In BOOT, SHALL hold f_gnt at 0 and grant l_gnt = l_req.
REQ-023 In RUN, SHALL grant at most one requester per cycle; arbitration per REQ-041.
REQ-024 SHALL drive grants combinationally from the current requests and state; a grant is the handshake, with no further acknowledge.
REQ-025 On a granted request, SHALL set m_en=1, m_addr=addr[ADDR_W+1:2], and m_we=1 with m_wdata=l_wdata for the loader or m_we=0 for fetch; otherwise m_en=0, m_we=0.
REQ-026 SHALL ignore addr[1:0] (word-aligned access).
REQ-027 Out-of-range address (any bit of addr[31:ADDR_W+2] set): loader write SHALL be granted but m_en held 0 (dropped); fetch SHALL be granted with m_en held 0 and f_rdata=NOP_WORD.
REQ-028 SHALL assert f_rvalid exactly one cycle after each f_gnt, with f_rdata=m_rdata for in-range fetches, or NOP_WORD if out of range per REQ-027.
REQ-029 SHALL drive f_rdata=NOP_WORD whenever f_rvalid=0.
REQ-030 l_done coinciding with l_req in BOOT: write SHALL complete; RUN SHALL take effect the next cycle.
REQ-031 l_done while already in RUN SHALL be ignored.
REQ-032 Fetch requests in BOOT SHALL be stalled, not dropped; the requester holds f_req until f_gnt.

Reset
REQ-033 While rst_n=0: state=BOOT, boot_done=0, f_gnt=0, l_gnt=0, f_rvalid=0, f_rdata=NOP_WORD, m_en=0, m_we=0, m_addr=0, m_wdata=0, RR pointer=loader.
REQ-034 Reset asserted mid-read SHALL cancel the pending f_rvalid.
REQ-035 On release, SHALL return to BOOT; memory contents are not cleared.

Configuration
REQ-041 With IMEM_RR_EN defined, RUN SHALL arbitrate round-robin: on conflict, grant the requester not granted last; the pointer updates only on a grant.
REQ-042 Without IMEM_RR_EN, RUN SHALL use fixed priority: loader always wins on conflict.

Verification
REQ-050 Reset, l_req writes 0x00100093 to byte addr 0x0, l_done -> boot_done=1 next cycle; fetch addr 0x0 -> f_rvalid next cycle with f_rdata=0x00100093.
REQ-051 f_req held in BOOT for 5 cycles -> f_gnt=0 throughout; first f_gnt the cycle after l_done.
REQ-052 RUN, f_req and l_req both held 4 cycles -> RR: grants alternate (loader first after reset); fixed: l_gnt all 4 cycles, f_gnt=0.
REQ-053 Fetch of byte addr 0x00001000 (ADDR_W=10) -> f_gnt=1, m_en=0, f_rdata=0x00000013; loader write there -> l_gnt=1, m_en=0.
REQ-054 rst_n low the cycle after f_gnt -> f_rvalid=0, state=BOOT, boot_done=0.
REQ-055 Fetch of byte addr 0x6 -> m_addr=1.
